frame_painter: RTL
==================

Name: frame_painter

Overview:
- Upstream writer for the 4x4-block pixel memory that the VGA scan-out stage reads through rmemaddr/memout.
- Accepts rectangle-fill and clear-screen commands over a valid/ready handshake.
- Clips each rectangle to the logical screen and writes one 3-bit colour code per cycle into the memory write port, in row-major order.
- The team's game logic drives the command interface.

Parameters:
- PX_WIDTH, 160, logical pixels per row (640/4)
- PX_HEIGHT, 120, logical rows (480/4)
- ADDR_W, 16, memory address width; PX_WIDTH*PX_HEIGHT must be at most 2^ADDR_W

Ports:
- dclk  input  1  pixel clock; all state changes on rising edge
- clr  input  1  asynchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  1  0 = fill rectangle, 1 = clear whole screen
- cmd_x  input  8  left column
- cmd_y  input  7  top row
- cmd_w  input  8  width in logical pixels
- cmd_h  input  7  height in logical pixels
- cmd_code  input  3  colour code to write
- wmemaddr  output  ADDR_W  write address, row*PX_WIDTH + col
- wmemdata  output  3  write data
- wmemwe  output  1  write enable; memory writes on a dclk edge while high
- busy  output  1  high whenever not IDLE
- done  output  1  one-cycle pulse at the end of every command

Behaviour:
- Reset: clr high asynchronously forces the IDLE state with wmemaddr=0, wmemdata=0, wmemwe=0, done=0, busy=0. cmd_ready goes to 1 in IDLE.
- Reset mid-command: the command is abandoned with no further writes and no done pulse. Pixels already written stay in memory.
- States: IDLE, SETUP, FILL, DONE. cmd_ready = (state==IDLE). busy = !IDLE.
- IDLE: on an edge with cmd_valid && cmd_ready, latch all cmd_* fields and go to SETUP. Command inputs are ignored when not IDLE.
- Clear (cmd_op=1): treat as a rectangle at x=0, y=0, w=PX_WIDTH, h=PX_HEIGHT. cmd_x/y/w/h are ignored.
- SETUP (one cycle), clipping:
  - x_end = min(x+w, PX_WIDTH), computed 9 bits wide.
  - y_end = min(y+h, PX_HEIGHT), computed 8 bits wide.
  - The rectangle is empty if w==0, h==0, x>=PX_WIDTH, or y>=PX_HEIGHT.
- SETUP, address base: row_base = y*PX_WIDTH is computed once here. It need not take a single cycle, but SETUP stays exactly one cycle.
- SETUP exit: empty rectangle goes to DONE; otherwise load col=x and row=y and go to FILL.
- FILL:
  - Each cycle: wmemwe=1, wmemaddr=row_base+col, wmemdata=latched code.
  - If col==x_end-1: col=x, row_base += PX_WIDTH, row += 1; if row==y_end-1 on that same cycle, go to DONE after this write. Otherwise col += 1.
  - No multiplier is used inside the FILL loop.
  - Outputs are registered, so wmemwe/addr/data are stable for the whole cycle.
- DONE (one cycle): done=1, wmemwe=0, then return to IDLE.
- Latency from the accept edge:
  - SETUP cycle 1.
  - First write visible in cycle 2; N clipped pixels occupy cycles 2..N+1.
  - done in cycle N+2; cmd_ready in cycle N+3.
  - For an empty rectangle, done is in cycle 2.
- Back-to-back: a new command can be accepted on the first IDLE edge. There are no gaps other than SETUP and DONE.
- wmemwe is 0 in every state except FILL. wmemaddr/wmemdata hold their last values when not writing.
- Write count per command is exactly (x_end-x)*(y_end-y) for a non-empty rectangle and 0 for an empty one. There are no duplicate or out-of-range addresses.

Test Plan:
- Reset then idle: cmd_ready=1, wmemwe=0, done=0. Assert clr mid-FILL (after 5 writes of a clear): wmemwe drops to 0 immediately, no done pulse, cmd_ready=1 after release.
- Fill x=10 y=5 w=2 h=2 code=3: exactly 4 writes in order to 810, 811, 970, 971 with data 3. done 6 cycles after accept; cmd_ready in the 7th.
- Clipped fill x=158 y=119 w=4 h=3 code=1: exactly writes to 19198 and 19199. Also x=200 (off-screen) w=5 h=5: zero writes, done 2 cycles after accept.
- Zero size: w=0 h=7 gives no writes, done in cycle 2. Likewise w=3 h=0.
- Clear code=2: 19200 writes with addresses 0..19199 strictly ascending and data 2 each. done in cycle 19202; busy high throughout.
- Back-to-back: hold cmd_valid high with two 1x1 commands at (0,0) and (159,119). Writes go to 0 then 19199, and the second command is accepted on the first edge cmd_ready is 1. Changing cmd_* while busy has no effect on the writes.

Source files
------------

// File: rtl/frame_painter_if.sv
// Command and memory-write bundle between the game logic (master)
// and frame_painter (slave).
interface frame_painter_if #(
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [7:0]        cmd_x;
  logic [6:0]        cmd_y;
  logic [7:0]        cmd_w;
  logic [6:0]        cmd_h;
  logic [2:0]        cmd_code;
  logic [ADDR_W-1:0] wmemaddr;
  logic [2:0]        wmemdata;
  logic              wmemwe;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_code,
    input  cmd_ready, wmemaddr, wmemdata, wmemwe, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_code,
    output cmd_ready, wmemaddr, wmemdata, wmemwe, busy, done
  );
endinterface

// File: rtl/frame_painter.sv
// Rectangle-fill / clear-screen writer for the 4x4-block pixel memory.
// Clips each command to the screen and writes one pixel per cycle, row-major.
module frame_painter #(
  parameter int PX_WIDTH  = 160,
  parameter int PX_HEIGHT = 120,
  parameter int ADDR_W    = 16
) (
  input logic             dclk,
  input logic             clr,
  frame_painter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [8:0]        PXW9  = 9'(PX_WIDTH);
  localparam logic [7:0]        PXW8  = 8'(PX_WIDTH);
  localparam logic [7:0]        PXH8  = 8'(PX_HEIGHT);
  localparam logic [6:0]        PXH7  = 7'(PX_HEIGHT);
  localparam logic [ADDR_W-1:0] PXW_A = ADDR_W'(PX_WIDTH);

  state_t            state_q, state_d;
  logic [7:0]        x_q, x_d, w_q, w_d, col_q, col_d;
  logic [6:0]        y_q, y_d, h_q, h_d, row_q, row_d;
  logic [8:0]        xend_q, xend_d;
  logic [7:0]        yend_q, yend_d;
  logic [2:0]        code_q, code_d, data_q, data_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic              we_q, we_d;

  logic [8:0]        x_sum;
  logic [7:0]        y_sum;
  logic              empty;
  logic [ADDR_W-1:0] setup_base;
  logic              last_col, last_row;

  assign x_sum      = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum      = {1'b0, y_q} + {1'b0, h_q};
  assign empty      = (w_q == 8'd0) || (h_q == 7'd0) ||
                      ({1'b0, x_q} >= PXW9) || ({1'b0, y_q} >= PXH8);
  assign setup_base = ADDR_W'(y_q) * PXW_A;
  assign last_col   = ({1'b0, col_q} == (xend_q - 9'd1));
  assign last_row   = ({1'b0, row_q} == (yend_q - 8'd1));

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      code_q     <= '0;
      xend_q     <= '0;
      yend_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      code_q     <= code_d;
      xend_q     <= xend_d;
      yend_q     <= yend_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

  // The output registers always hold the pixel at (col_q, row_q); each edge
  // in FILL loads the next pixel, so the address is ready one cycle early.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    code_d     = code_q;
    xend_d     = xend_q;
    yend_d     = yend_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op) begin
            x_d = 8'd0;
            y_d = 7'd0;
            w_d = PXW8;
            h_d = PXH7;
          end else begin
            x_d = bus.cmd_x;
            y_d = bus.cmd_y;
            w_d = bus.cmd_w;
            h_d = bus.cmd_h;
          end
          code_d  = bus.cmd_code;
          state_d = SETUP;
        end
      end
      SETUP: begin
        xend_d = (x_sum > PXW9) ? PXW9 : x_sum;
        yend_d = (y_sum > PXH8) ? PXH8 : y_sum;
        if (empty) begin
          state_d = DONE;
        end else begin
          col_d      = x_q;
          row_d      = y_q;
          row_base_d = setup_base;
          addr_d     = setup_base + ADDR_W'(x_q);
          data_d     = code_q;
          we_d       = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        we_d = 1'b1;
        if (last_col) begin
          if (last_row) begin
            we_d    = 1'b0;
            state_d = DONE;
          end else begin
            col_d      = x_q;
            row_d      = row_q + 7'd1;
            row_base_d = row_base_q + PXW_A;
            addr_d     = row_base_q + PXW_A + ADDR_W'(x_q);
          end
        end else begin
          col_d  = col_q + 8'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.wmemaddr  = addr_q;
  assign bus.wmemdata  = data_q;
  assign bus.wmemwe    = we_q;

endmodule
